rf_wport_arb: RTL and testbench
===============================

RF_WPORT_ARB -- requirements
Module: rf_wport_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive blocked cycles of a non-empty FIFO before a WB stall is forced; legal range is 1..15.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 wb_we  input  1  WB stage register-write request; already qualified by WB_valid, !wb_ex and !ertn_flush.
REQ-005 wb_waddr  input  5  WB destination register.
REQ-006 wb_wdata  input  32  WB write data.
REQ-007 wb_stall  output  1  registered; when 1, the WB stage SHALL hold its instruction (ready_go=0) this cycle.
REQ-008 lu_valid  input  1  long-latency unit (divider / late load) write request.
REQ-009 lu_ready  output  1  FIFO can accept an entry this cycle.
REQ-010 lu_waddr  input  5  long-latency destination register.
REQ-011 lu_wdata  input  32  long-latency write data.
REQ-012 lu_pend_mask  output  32  bit i set when any valid FIFO entry targets register i; ID interlock source.
REQ-013 rf_we  output  1  register-file write enable.
REQ-014 rf_waddr  output  5  register-file write address.
REQ-015 rf_wdata  output  32  register-file write data.

Function
REQ-016 The FIFO SHALL have 2 entries {waddr, wdata}, a 2-bit count, and wrap-around read/write pointers.
REQ-017 lu_ready SHALL be 1 iff count<2; it is computed from registered state only, with no dependency on a same-cycle pop.
REQ-018 A push SHALL occur when lu_valid && lu_ready; if lu_waddr==0, the request is accepted and discarded with no push.
REQ-019 Port priority: (wb_we && !wb_stall) wins; otherwise FIFO head when count>0; otherwise idle.
REQ-020 When FIFO head is granted, it SHALL pop that cycle, with rf_we=1, rf_waddr=head.waddr and rf_wdata=head.wdata.
REQ-021 When WB is granted, outputs SHALL be rf_we=(wb_waddr!=0), rf_waddr=wb_waddr and rf_wdata=wb_wdata, all combinational.
REQ-022 wb_we while wb_stall=1 SHALL NOT write; the WB stage re-presents it the next cycle.
REQ-023 Simultaneous push and pop at count 1 SHALL leave count at 1; a push at count 2 is impossible by REQ-017.
REQ-024 starve_cnt (4 bits) SHALL increment each cycle count>0 and the head is not popped, and clear on any pop or when count==0.
REQ-025 wb_stall SHALL be set for exactly one cycle in the cycle after starve_cnt reaches STARVE_MAX; starve_cnt clears when wb_stall is set.
REQ-026 lu_pend_mask bit 0 SHALL always be 0; the mask reflects registered FIFO contents only.
REQ-027 Cross-source ordering to the same register is not enforced here; issue logic SHALL use lu_pend_mask.

Reset
REQ-028 On reset: count=0, pointers=0, starve_cnt=0, wb_stall=0, lu_pend_mask=0, lu_ready=1, and rf_we=0 unless wb_we.
REQ-029 Reset mid-operation SHALL discard all buffered entries with no write issued.

Configuration
REQ-030 With RF_ARB_BYPASS_EN defined: when count==0 and the port is not granted to WB, a valid lu write (waddr!=0) SHALL go directly to the port the same cycle without a push.
REQ-031 Without RF_ARB_BYPASS_EN: every lu write SHALL pass through the FIFO, giving a minimum latency of 1 cycle.

Verification
REQ-032 Idle WB, lu_valid with waddr=5 and wdata=0xDEAD0001 at cycle 0 -> rf_we=1, waddr 5 at cycle 0 with bypass, cycle 1 without.
REQ-033 wb_we=1 every cycle, 2 lu pushes (r3, r4), STARVE_MAX=4 -> wb_stall=1 at cycle 5, r3 written at cycle 5, and the cycle repeats for r4.
REQ-034 FIFO full (r6, r7) -> lu_ready=0 and lu_pend_mask=0x000000C0; after a pop, lu_ready=1 the next cycle.
REQ-035 lu push to r0 and wb write to r0 -> rf_we=0, count unchanged, lu_pend_mask=0.
REQ-036 FIFO holding 2 entries, reset=1 for one cycle -> count=0, lu_pend_mask=0, wb_stall=0, and no rf write from the dropped entries.

Source files
------------

// File: rtl/rf_wport_arb.sv
// rtl/rf_wport_arb.sv - register-file write-port arbiter: WB stage vs a 2-entry long-latency FIFO
// Optional same-cycle lu bypass when the FIFO is empty: define RF_ARB_BYPASS_EN.
module rf_wport_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  output logic        wb_stall,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  output logic [31:0] lu_pend_mask,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [4:0]  waddr_q [2];
  logic [31:0] wdata_q [2];
  logic [1:0]  cnt_q, cnt_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [3:0]  starve_q, starve_d;
  logic        stall_q, stall_d;
  logic        wb_grant, head_grant, byp, push, lu_acc;
  logic [31:0] mask;

  always_comb begin
    wb_grant   = wb_we && !stall_q;
    lu_ready   = (cnt_q < 2'd2);
    lu_acc     = lu_valid && lu_ready;
    // A pop during reset would write an entry that reset is about to drop.
    head_grant = !wb_grant && (cnt_q != 2'd0) && !reset;
    byp        = 1'b0;
`ifdef RF_ARB_BYPASS_EN
    byp        = !wb_grant && (cnt_q == 2'd0) && lu_acc && (lu_waddr != 5'd0) && !reset;
`endif
    push       = lu_acc && (lu_waddr != 5'd0) && !byp;

    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (wb_grant) begin
      rf_we    = (wb_waddr != 5'd0);
      rf_waddr = wb_waddr;
      rf_wdata = wb_wdata;
    end else if (head_grant) begin
      rf_we    = 1'b1;
      rf_waddr = waddr_q[rd_ptr_q];
      rf_wdata = wdata_q[rd_ptr_q];
    end else if (byp) begin
      rf_we    = 1'b1;
      rf_waddr = lu_waddr;
      rf_wdata = lu_wdata;
    end

    cnt_d    = cnt_q + {1'b0, push} - {1'b0, head_grant};
    rd_ptr_d = rd_ptr_q ^ head_grant;
    wr_ptr_d = wr_ptr_q ^ push;

    // Raising the stall and clearing the counter happen together.
    starve_d = 4'd0;
    stall_d  = 1'b0;
    if (!head_grant && (cnt_q != 2'd0)) begin
      if (starve_q + 4'd1 == StarveMax) stall_d = 1'b1;
      else starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    mask = 32'd0;
    for (int i = 0; i < 2; i++) begin
      if ((cnt_q == 2'd2) || ((cnt_q == 2'd1) && (rd_ptr_q == 1'(i))))
        mask[waddr_q[i]] = 1'b1;
    end
    mask[0] = 1'b0;
  end

  assign lu_pend_mask = mask;
  assign wb_stall     = stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      starve_q <= 4'd0;
      stall_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      waddr_q[wr_ptr_q] <= lu_waddr;
      wdata_q[wr_ptr_q] <= lu_wdata;
    end
  end

endmodule

// File: tb/tb_rf_wport_arb.sv
// tb/tb_rf_wport_arb.sv - self-checking bench for rf_wport_arb
module tb_rf_wport_arb;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_stall;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic [31:0] lu_pend_mask;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int cmp_cnt = 0;
  int err_cnt = 0;
  bit chk_en  = 1'b0;

  rf_wport_arb #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_stall(wb_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .lu_pend_mask(lu_pend_mask),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO as a queue of {waddr, wdata}, plus starvation bookkeeping.
  logic [36:0] mq[$];
  logic [36:0] nq[$];
  int          m_starve = 0, n_starve;
  bit          m_stall = 1'b0, n_stall;
  bit          wbg, rdy, acc, popd, byp, e_we;
  logic [4:0]  e_a;
  logic [31:0] e_d, e_mask;

  always @(negedge clk) begin
    if (chk_en) begin
      wbg  = wb_we && !m_stall;
      rdy  = (mq.size() < 2);
      acc  = lu_valid && rdy;
      popd = 1'b0;
      byp  = 1'b0;
      e_we = 1'b0;
      e_a  = 5'd0;
      e_d  = 32'd0;
      e_mask = 32'd0;
      foreach (mq[k]) e_mask[mq[k][36:32]] = 1'b1;
      e_mask[0] = 1'b0;
      if (wbg) begin
        e_we = (wb_waddr != 5'd0);
        e_a  = wb_waddr;
        e_d  = wb_wdata;
      end else if (!reset && mq.size() > 0) begin
        e_we = 1'b1;
        e_a  = mq[0][36:32];
        e_d  = mq[0][31:0];
        popd = 1'b1;
      end
`ifdef RF_ARB_BYPASS_EN
      else if (!reset && acc && lu_waddr != 5'd0) begin
        e_we = 1'b1;
        e_a  = lu_waddr;
        e_d  = lu_wdata;
        byp  = 1'b1;
      end
`endif
      chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
      if (e_we) begin
        chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e_a});
        chk("rf_wdata", rf_wdata, e_d);
      end
      chk("lu_ready", {31'd0, lu_ready}, {31'd0, rdy});
      chk("lu_pend_mask", lu_pend_mask, e_mask);
      chk("wb_stall", {31'd0, wb_stall}, {31'd0, m_stall});

      nq = mq;
      if (reset) begin
        nq.delete();
        n_starve = 0;
        n_stall  = 1'b0;
      end else begin
        if (popd) void'(nq.pop_front());
        if (acc && lu_waddr != 5'd0 && !byp) nq.push_back({lu_waddr, lu_wdata});
        if (popd || mq.size() == 0) begin
          n_starve = 0;
          n_stall  = 1'b0;
        end else if (m_starve + 1 == SMAX) begin
          n_starve = 0;
          n_stall  = 1'b1;
        end else begin
          n_starve = m_starve + 1;
          n_stall  = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (chk_en) begin
      mq       = nq;
      m_starve = n_starve;
      m_stall  = n_stall;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld);
    wb_we = we; wb_waddr = wa; wb_wdata = wd;
    lu_valid = lv; lu_waddr = la; lu_wdata = ld;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    nxt();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_lu_ready", {31'd0, lu_ready}, 32'd1);
    chk("rst_mask", lu_pend_mask, 32'd0);
    chk("rst_wb_stall", {31'd0, wb_stall}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);

    // Single lu write, idle WB
    nxt(); reset = 1'b0;
    drive(0, 0, 0, 1, 5'd5, 32'hDEAD0001);
    @(negedge clk);
`ifdef RF_ARB_BYPASS_EN
    chk("t1_c0_we", {31'd0, rf_we}, 32'd1);
    chk("t1_c0_addr", {27'd0, rf_waddr}, 32'd5);
`else
    chk("t1_c0_we", {31'd0, rf_we}, 32'd0);
`endif
    nxt(); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef RF_ARB_BYPASS_EN
    chk("t1_c1_we", {31'd0, rf_we}, 32'd0);
`else
    chk("t1_c1_we", {31'd0, rf_we}, 32'd1);
    chk("t1_c1_addr", {27'd0, rf_waddr}, 32'd5);
    chk("t1_c1_data", rf_wdata, 32'hDEAD0001);
`endif

    // WB busy every cycle, two lu pushes starve until forced stalls
    for (int c = 0; c < 12; c++) begin
      nxt();
      drive(1, 5'd1, 32'h1000 + c, c < 2, 5'(3 + c), 32'hA000 + c);
      @(negedge clk);
      chk("t2_stall", {31'd0, wb_stall}, {31'd0, (c == 5 || c == 10)});
      if (c == 5) chk("t2_r3", {26'd0, rf_we, rf_waddr}, {26'd0, 1'b1, 5'd3});
      if (c == 10) chk("t2_r4", {26'd0, rf_we, rf_waddr}, {26'd0, 1'b1, 5'd4});
    end

    // Fill FIFO with r6, r7
    nxt(); drive(1, 5'd2, 32'h22, 1, 5'd6, 32'h66);
    nxt(); drive(1, 5'd2, 32'h22, 1, 5'd7, 32'h77);
    nxt(); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t3_full_ready", {31'd0, lu_ready}, 32'd0);
    chk("t3_full_mask", lu_pend_mask, 32'h000000C0);
    chk("t3_pop_r6", {27'd0, rf_waddr}, 32'd6);
    nxt();
    @(negedge clk);
    chk("t3_ready_after_pop", {31'd0, lu_ready}, 32'd1);
    chk("t3_mask_after_pop", lu_pend_mask, 32'h00000080);
    chk("t3_pop_r7", {27'd0, rf_waddr}, 32'd7);

    // Both sources target r0
    nxt(); drive(1, 5'd0, 32'h55, 1, 5'd0, 32'h99);
    @(negedge clk);
    chk("t4_r0_we", {31'd0, rf_we}, 32'd0);
    nxt(); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t4_r0_mask", lu_pend_mask, 32'd0);
    chk("t4_r0_ready", {31'd0, lu_ready}, 32'd1);

    // Reset with two buffered entries
    nxt(); drive(1, 5'd9, 32'h99, 1, 5'd10, 32'hAA);
    nxt(); drive(1, 5'd9, 32'h99, 1, 5'd11, 32'hBB);
    nxt(); drive(0, 0, 0, 0, 0, 0); reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_we", {31'd0, rf_we}, 32'd0);
    nxt(); reset = 1'b0;
    @(negedge clk);
    chk("t5_mask", lu_pend_mask, 32'd0);
    chk("t5_ready", {31'd0, lu_ready}, 32'd1);
    chk("t5_stall", {31'd0, wb_stall}, 32'd0);
    chk("t5_we", {31'd0, rf_we}, 32'd0);

    // Mixed traffic, model-checked
    for (int i = 0; i < 40; i++) begin
      nxt();
      drive(i % 3 != 0, 5'((i * 7) % 32), 32'hB000 + i, i % 2 == 0, 5'(i % 8), 32'hC000 + i);
    end
    nxt(); drive(0, 0, 0, 0, 0, 0);
    repeat (4) nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
